// File: rtl/kgprisc_run_ctrl.sv
// kgprisc_run_ctrl: program loader and run/step/halt control for the KGP-RISC core,
// with saturating cycle and retired-instruction counters.
module kgprisc_run_ctrl #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    input  logic [1:0]        cmd_op,
    output logic              cmd_ready,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [DATA_W-1:0] imem_wdata,
    output logic              core_rst_n,
    output logic              core_en,
    input  logic              core_retire,
    input  logic              core_halt,
    output logic [2:0]        state,
    output logic [CNT_W-1:0]  cycle_cnt,
    output logic [CNT_W-1:0]  retire_cnt,
    output logic              err_ovf
);
    typedef enum logic [2:0] {IDLE = 3'd0, LOAD = 3'd1, RUN = 3'd2, STEP = 3'd3, HALTED = 3'd4} state_t;
    localparam logic [1:0] OP_RUN = 2'b00, OP_STEP = 2'b01, OP_HALT = 2'b10, OP_LOAD = 2'b11;

    state_t cur, nxt;
    logic [ADDR_W-1:0] ptr, ptr_nxt;
    logic ovf_nxt, clr, acc;

    // Gating with rst keeps every handshake and core control low while reset is asserted.
    assign cmd_ready  = rst & (cur == IDLE || cur == RUN || cur == HALTED);
    assign ld_ready   = rst & (cur == LOAD);
    assign core_en    = rst & (cur == RUN || cur == STEP);
    assign core_rst_n = rst & (cur == RUN || cur == STEP || cur == HALTED);
    assign imem_we    = ld_valid & ld_ready;
    assign imem_addr  = ptr;
    assign imem_wdata = ld_data;
    assign state      = cur;
    assign acc        = cmd_valid & cmd_ready;

    always_comb begin
        nxt     = cur;
        ptr_nxt = ptr;
        ovf_nxt = err_ovf;
        clr     = 1'b0;
        case (cur)
            IDLE: if (acc) begin
                case (cmd_op)
                    OP_RUN:  begin nxt = RUN;  clr = 1'b1; end
                    OP_STEP: begin nxt = STEP; clr = 1'b1; end
                    OP_LOAD: begin nxt = LOAD; ptr_nxt = '0; ovf_nxt = 1'b0; end
                    default: nxt = IDLE;
                endcase
            end
            LOAD: if (imem_we) begin
                ptr_nxt = ptr + 1'b1;
                // The last address is written but the load stops there instead of wrapping.
                if (ld_last) nxt = IDLE;
                else if (&ptr) begin
                    nxt     = IDLE;
                    ovf_nxt = 1'b1;
                end
            end
            RUN:  if (core_halt || (acc && cmd_op == OP_HALT)) nxt = HALTED;
            STEP: nxt = HALTED;
            HALTED: if (acc) begin
                case (cmd_op)
                    OP_RUN:  nxt = RUN;
                    OP_STEP: nxt = STEP;
                    OP_LOAD: begin nxt = LOAD; ptr_nxt = '0; ovf_nxt = 1'b0; end
                    default: nxt = HALTED;
                endcase
            end
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cur     <= IDLE;
            ptr     <= '0;
            err_ovf <= 1'b0;
        end else begin
            cur     <= nxt;
            ptr     <= ptr_nxt;
            err_ovf <= ovf_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst || clr) begin
            cycle_cnt  <= '0;
            retire_cnt <= '0;
        end else if (core_en) begin
            cycle_cnt  <= cycle_cnt + CNT_W'(~&cycle_cnt);
            retire_cnt <= retire_cnt + CNT_W'(core_retire & ~&retire_cnt);
        end
    end
endmodule

// File: tb/tb_kgprisc_run_ctrl.sv
// tb_kgprisc_run_ctrl: directed scenarios plus random traffic against a
// cycle-level behavioural model of the run controller.
module tb_kgprisc_run_ctrl;
    localparam int ADDR_W = 2, DATA_W = 32, CNT_W = 4;
    localparam int DEPTH = 1 << ADDR_W;
    localparam int CMAX = (1 << CNT_W) - 1;

    logic clk = 0, rst = 0, cmd_valid = 0, ld_valid = 0, ld_last = 0, core_retire = 0, core_halt = 0;
    logic [1:0] cmd_op = 0;
    logic [DATA_W-1:0] ld_data = 0;
    logic cmd_ready, ld_ready, imem_we, core_rst_n, core_en, err_ovf;
    logic [ADDR_W-1:0] imem_addr;
    logic [DATA_W-1:0] imem_wdata;
    logic [2:0] state;
    logic [CNT_W-1:0] cycle_cnt, retire_cnt;

    kgprisc_run_ctrl #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_op(cmd_op), .cmd_ready(cmd_ready),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
        .core_rst_n(core_rst_n), .core_en(core_en), .core_retire(core_retire), .core_halt(core_halt),
        .state(state), .cycle_cnt(cycle_cnt), .retire_cnt(retire_cnt), .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_fail = 0;
    int m_state = 0, m_ptr = 0, m_cyc = 0, m_ret = 0, m_ovf = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int x);
        return x > CMAX ? CMAX : x;
    endfunction

    // Checks combinational outputs for the current inputs, advances the model one edge,
    // then checks the registered outputs after the edge.
    task automatic tick();
        bit e_rdy, e_ld, e_en, e_rn, acc, we;
        #1;
        e_rdy = rst && (m_state == 0 || m_state == 2 || m_state == 4);
        e_ld  = rst && m_state == 1;
        e_en  = rst && (m_state == 2 || m_state == 3);
        e_rn  = rst && m_state >= 2;
        we    = ld_valid && e_ld;
        acc   = cmd_valid && e_rdy;
        chk("cmd_ready", cmd_ready, e_rdy);
        chk("ld_ready", ld_ready, e_ld);
        chk("core_en", core_en, e_en);
        chk("core_rst_n", core_rst_n, e_rn);
        chk("imem_we", imem_we, we);
        if (we) begin
            chk("imem_addr", imem_addr, m_ptr);
            chk("imem_wdata", imem_wdata, ld_data);
        end
        if (!rst) begin
            m_state = 0; m_ptr = 0; m_cyc = 0; m_ret = 0; m_ovf = 0;
        end else begin
            if (e_en) begin
                m_cyc = sat(m_cyc + 1);
                if (core_retire) m_ret = sat(m_ret + 1);
            end
            case (m_state)
                0: if (acc) begin
                    if (cmd_op == 3) begin m_state = 1; m_ptr = 0; m_ovf = 0; end
                    else if (cmd_op != 2) begin m_state = cmd_op == 0 ? 2 : 3; m_cyc = 0; m_ret = 0; end
                end
                1: if (we) begin
                    if (ld_last) m_state = 0;
                    else if (m_ptr == DEPTH - 1) begin m_state = 0; m_ovf = 1; end
                    m_ptr = (m_ptr + 1) % DEPTH;
                end
                2: if (core_halt || (acc && cmd_op == 2)) m_state = 4;
                3: m_state = 4;
                4: if (acc) begin
                    if (cmd_op == 0) m_state = 2;
                    else if (cmd_op == 1) m_state = 3;
                    else if (cmd_op == 3) begin m_state = 1; m_ptr = 0; m_ovf = 0; end
                end
                default: m_state = 0;
            endcase
        end
        @(posedge clk);
        #1;
        chk("state", state, m_state);
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("retire_cnt", retire_cnt, m_ret);
        chk("err_ovf", err_ovf, m_ovf);
    endtask

    task automatic drive(input logic r, input logic cv, input logic [1:0] op, input logic lv,
                         input logic [DATA_W-1:0] d, input logic ll, input logic cr, input logic ch);
        @(negedge clk);
        rst = r; cmd_valid = cv; cmd_op = op; ld_valid = lv; ld_data = d; ld_last = ll;
        core_retire = cr; core_halt = ch;
        tick();
    endtask

    task automatic cmd(input logic [1:0] op);
        drive(1, 1, op, 0, 0, 0, 0, 0);
    endtask

    task automatic idle(input int n, input logic cr);
        for (int i = 0; i < n; i++) drive(1, 0, 0, 0, 0, 0, cr, 0);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_state", state, 0);
        chk("rst_cyc", cycle_cnt, 0);
        chk("rst_ovf", err_ovf, 0);
        chk("rst_cmd_ready", cmd_ready, 0);

        // Four-word load, last flagged on the fourth.
        cmd(3);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 32'hA000_0000 + i * 32'h1111, i == 3, 0, 0);
        chk("t1_state", state, 0);
        chk("t1_ovf", err_ovf, 0);

        // Overrun: four words without last, the fifth is refused.
        cmd(3);
        for (int i = 0; i < 4; i++) drive(1, 0, 0, 1, 32'hB000_0000 + i, 0, 0, 0);
        chk("t2_state", state, 0);
        chk("t2_ovf", err_ovf, 1);
        drive(1, 0, 0, 1, 32'hB000_0004, 0, 0, 0);
        chk("t2_ld_ready", ld_ready, 0);

        // Run ten cycles with six retirements, then halt.
        cmd(0);
        for (int i = 0; i < 10; i++) drive(1, 0, 0, 0, 0, 0, i < 6, 0);
        cmd(2);
        chk("t3_state", state, 4);
        chk("t3_cyc", cycle_cnt, 11);
        chk("t3_ret", retire_cnt, 6);

        // Three single steps from HALTED.
        for (int i = 0; i < 3; i++) begin
            cmd(1);
            chk("t4_step_state", state, 3);
            idle(1, 1);
            chk("t4_halt_state", state, 4);
        end
        chk("t4_cyc", cycle_cnt, 14);

        // Simultaneous HALT command and core_halt, then resume.
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        cmd(0);
        idle(2, 0);
        drive(1, 1, 2, 0, 0, 0, 1, 1);
        chk("t5_state", state, 4);
        idle(2, 0);
        chk("t5_hold", state, 4);
        cmd(0);
        chk("t5_resume", state, 2);
        chk("t5_cyc", cycle_cnt, 3);
        chk("t5_ret", retire_cnt, 1);
        cmd(2);

        // Reset during a load, reload from address 0, then counter saturation.
        cmd(3);
        for (int i = 0; i < 2; i++) drive(1, 0, 0, 1, 32'hC0 + i, 0, 0, 0);
        drive(0, 0, 0, 1, 32'hC2, 0, 0, 0);
        chk("t6_state", state, 0);
        chk("t6_core_rst_n", core_rst_n, 0);
        cmd(3);
        drive(1, 0, 0, 1, 32'hD0, 1, 0, 0);
        cmd(0);
        idle(20, 1);
        chk("t6_sat_cyc", cycle_cnt, 15);
        chk("t6_sat_ret", retire_cnt, 15);

        // Random traffic.
        for (int i = 0; i < 1500; i++)
            drive($urandom_range(0, 49) != 0, $urandom_range(0, 3) == 0, 2'($urandom), $urandom_range(0, 1),
                  $urandom, $urandom_range(0, 5) == 0, $urandom_range(0, 1), $urandom_range(0, 15) == 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
